// File: rtl/clk_div_pkg.sv
// Shared types and default ratios for the runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPend,
    StStop
  } state_e;

  localparam int unsigned DefDivRatio = 10;
  localparam int unsigned MinDivRatio = 2;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, duty compare and registered clk_out/tick.
module clk_div_core #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             wrap_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  assign wrap_o    = (cnt_q == div_i - CNT_W'(1));
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

  // A stopped divider parks at cnt=0 with clk_out low; load restarts a fresh period.
  always_comb begin
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (run_i) begin
      if (!load_i && !wrap_o) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      clk_out_d = (cnt_d < (div_i >> 1));
      tick_d    = (cnt_d == '0) && clk_out_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Configuration sequencer: ratio handshake, shadow register and start/stop FSM
// wrapped around the divider datapath.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = DefDivRatio,
  parameter int unsigned MIN_DIV = MinDivRatio
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             xfer, legal, load, wrap;

  assign cfg_ready = (state_q == StIdle) || (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = (cfg_div >= CNT_W'(MIN_DIV));
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    cfg_err_d = xfer & ~legal;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer && legal) begin
          div_d = cfg_div;
        end
        if (en) begin
          state_d = StRun;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (xfer && legal) begin
          shadow_d = cfg_div;
          pend_d   = 1'b1;
        end
        if (!en) begin
          state_d = StStop;
        end else if (xfer && legal) begin
          state_d = StPend;
        end
      end
      StPend: begin
        if (wrap) begin
          div_d   = shadow_q;
          pend_d  = 1'b0;
          state_d = en ? StRun : StStop;
        end else if (!en) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // A ratio captured alongside the stop request still takes effect.
        if (wrap) begin
          if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      div_q     <= CNT_W'(DEF_DIV);
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i     (clk_in),
    .rst_ni    (rst),
    .run_i     (state_d != StIdle),
    .load_i    (load),
    .div_i     (div_q),
    .wrap_o    (wrap),
    .clk_out_o (clk_out),
    .tick_o    (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: expected tick cycles and clk_out high-phase lengths are
// queued as stimulus is applied and consumed by a monitor on the falling edge.
module tb_clk_div_ctrl;

  localparam int unsigned CntW = 16;

  logic            clk_in    = 1'b0;
  logic            rst       = 1'b1;
  logic            en        = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [CntW-1:0] cfg_div   = '0;
  logic            cfg_ready, clk_out, tick, busy, cfg_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;
  int high_run = 0;
  int c        = 0;
  int exp_tick_q[$];
  int exp_high_q[$];

  clk_div_ctrl #(
    .CNT_W   (CntW),
    .DEF_DIV (10),
    .MIN_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic push_run(input int first, input int period, input int n, input int high);
    for (int i = 0; i < n; i++) begin
      exp_tick_q.push_back(first + period * i);
      if (high > 0) exp_high_q.push_back(high);
    end
  endtask

  task automatic cfg_idle(input int div);
    cfg_valid = 1'b1;
    cfg_div   = CntW'(div);
    check_eq("idle_cfg_ready", int'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    check_eq("idle_cfg_err", int'(cfg_err), 0);
  endtask

  // Monitor: every tick must match the next expected cycle, every high phase its length.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst) begin
        high_run = 0;
      end else begin
        if (tick) begin
          if (exp_tick_q.size() == 0) check_eq("tick_unexp", int'(tick), 0);
          else check_eq("tick_cycle", cyc, exp_tick_q.pop_front());
        end
        if (clk_out) begin
          high_run++;
        end else if (high_run > 0) begin
          if (exp_high_q.size() == 0) check_eq("high_unexp", high_run, 0);
          else check_eq("high_len", high_run, exp_high_q.pop_front());
          high_run = 0;
        end
      end
    end
  end

  initial begin
    #3 rst = 1'b0;
    step(2);
    check_eq("rst_clk_out", int'(clk_out), 0);
    check_eq("rst_tick", int'(tick), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_cfg_err", int'(cfg_err), 0);
    check_eq("rst_cfg_ready", int'(cfg_ready), 1);
    rst = 1'b1;
    step(2);

    // Default ratio 10, stop requested at cnt=2 of the third period.
    c  = cyc;
    en = 1'b1;
    push_run(c + 1, 10, 3, 5);
    step(1);
    check_eq("run_busy", int'(busy), 1);
    check_eq("run_clk_first", int'(clk_out), 1);
    step(22);
    en = 1'b0;
    step(7);
    check_eq("stop_busy", int'(busy), 1);
    step(1);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_clk_out", int'(clk_out), 0);
    check_eq("idle_ready", int'(cfg_ready), 1);
    step(12);

    // Ratio 4 requested at cnt=3; applied only at the period boundary.
    c  = cyc;
    en = 1'b1;
    exp_tick_q.push_back(c + 1);
    exp_high_q.push_back(5);
    push_run(c + 11, 4, 3, 2);
    step(4);
    cfg_valid = 1'b1;
    cfg_div   = CntW'(4);
    check_eq("run_cfg_ready", int'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    check_eq("pend_ready", int'(cfg_ready), 0);
    step(5);
    check_eq("pend_ready_late", int'(cfg_ready), 0);
    step(1);
    check_eq("applied_ready", int'(cfg_ready), 1);
    step(10);
    en = 1'b0;
    step(2);
    check_eq("n4_idle_busy", int'(busy), 0);
    step(6);

    // Odd ratio 5 programmed while idle: high 2, low 3.
    cfg_idle(5);
    c  = cyc;
    en = 1'b1;
    push_run(c + 1, 5, 3, 2);
    step(13);
    en = 1'b0;
    step(3);
    check_eq("n5_idle_busy", int'(busy), 0);
    step(6);

    // Asynchronous reset mid-high-phase restores the default ratio.
    cfg_idle(8);
    c  = cyc;
    en = 1'b1;
    exp_tick_q.push_back(c + 1);
    step(4);
    check_eq("pre_rst_clk", int'(clk_out), 1);
    rst = 1'b0;
    #1;
    check_eq("async_rst_clk", int'(clk_out), 0);
    check_eq("async_rst_busy", int'(busy), 0);
    step(2);
    check_eq("in_rst_tick", int'(tick), 0);
    c = cyc;
    push_run(c + 1, 10, 3, 5);
    rst = 1'b1;

    // Illegal ratio 1 while running: accepted, flagged, ignored.
    step(4);
    cfg_valid = 1'b1;
    cfg_div   = CntW'(1);
    check_eq("bad_cfg_ready", int'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    check_eq("bad_cfg_err", int'(cfg_err), 1);
    check_eq("bad_still_ready", int'(cfg_ready), 1);
    step(1);
    check_eq("bad_err_pulse", int'(cfg_err), 0);
    step(17);
    en = 1'b0;
    step(8);
    check_eq("bad_idle_busy", int'(busy), 0);
    step(6);

    // Minimum legal ratio 2.
    cfg_idle(2);
    c  = cyc;
    en = 1'b1;
    push_run(c + 1, 2, 4, 1);
    step(7);
    en = 1'b0;
    step(1);
    check_eq("n2_stop_busy", int'(busy), 1);
    step(1);
    check_eq("n2_idle_busy", int'(busy), 0);
    step(4);

    // Stop and legal request on the same edge: shadow applied before idling.
    cfg_idle(6);
    c  = cyc;
    en = 1'b1;
    push_run(c + 1, 6, 1, 3);
    step(3);
    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = CntW'(3);
    check_eq("simul_ready", int'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    check_eq("simul_stop_ready", int'(cfg_ready), 0);
    check_eq("simul_cfg_err", int'(cfg_err), 0);
    step(3);
    check_eq("simul_idle_busy", int'(busy), 0);
    c  = cyc;
    en = 1'b1;
    push_run(c + 1, 3, 2, 1);
    step(5);
    en = 1'b0;
    step(2);
    check_eq("n3_idle_busy", int'(busy), 0);
    step(6);

    check_eq("tick_left", exp_tick_q.size(), 0);
    check_eq("high_left", exp_high_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
